// File: rtl/histo_uart_receiver.sv
// Histogram serial link receiver: deserializes one 24-bit word per bin,
// tags it with its bin index and accumulates the frame pixel total.
module histo_uart_receiver #(
  parameter int DATA_WIDTH   = 24,
  parameter int NUM_BINS     = 1024,
  parameter int BIN_WIDTH    = 10,
  parameter int CLKS_PER_BIT = 10,
  parameter int TIMEOUT_CLKS = 4096,
  parameter int SUM_WIDTH    = 34
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  serial_in,
  output logic [DATA_WIDTH-1:0] word_data,
  output logic [BIN_WIDTH-1:0]  word_bin,
  output logic                  word_valid,
  output logic                  frame_done,
  output logic [SUM_WIDTH-1:0]  frame_sum,
  output logic                  framing_err,
  output logic                  frame_abort,
  output logic                  busy
);

  localparam int HALF = CLKS_PER_BIT / 2;
  localparam int TW   = $clog2(CLKS_PER_BIT);
  localparam int CW   = $clog2(DATA_WIDTH + 1);
  localparam int IW   = $clog2(TIMEOUT_CLKS + 1);

  typedef enum logic [2:0] {
    IDLE, START, DATA, STOP, WAIT_HIGH
  } state_t;

  state_t state_q, state_d;

  logic                  s1, rx, rx_d;
  logic [TW-1:0]         tmr_q;
  logic [CW-1:0]         bit_q;
  logic [DATA_WIDTH-1:0] shreg_q;
  logic [BIN_WIDTH-1:0]  bin_q;
  logic [SUM_WIDTH-1:0]  sum_q, sum_nx;
  logic [IW-1:0]         idle_q;

  logic start_det, bit_end, data_smp, stop_smp;
  logic last_bin, idle_run, timeout;

  assign bit_end  = tmr_q == TW'(CLKS_PER_BIT - 1);
  assign data_smp = (state_q == DATA) && bit_end;
  assign stop_smp = (state_q == STOP) && bit_end;
  assign sum_nx   = sum_q + SUM_WIDTH'(shreg_q);
  assign last_bin = bin_q == BIN_WIDTH'(NUM_BINS - 1);
  assign idle_run = (state_q == IDLE) && !start_det
                    && (bin_q != '0);
  assign timeout  = idle_run && (idle_q == IW'(TIMEOUT_CLKS - 1));
  assign busy     = state_q != IDLE;

  always_comb begin
    state_d   = state_q;
    start_det = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (rx_d && !rx) begin
          state_d   = START;
          start_det = 1'b1;
        end
      end
      START: begin
        if (tmr_q == TW'(HALF - 1))
          state_d = rx ? IDLE : DATA;
      end
      DATA: begin
        if (bit_end && bit_q == CW'(DATA_WIDTH - 1))
          state_d = STOP;
      end
      STOP: begin
        if (bit_end)
          state_d = rx ? IDLE : WAIT_HIGH;
      end
      WAIT_HIGH: begin
        if (rx)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1          <= 1'b1;
      rx          <= 1'b1;
      rx_d        <= 1'b1;
      tmr_q       <= '0;
      bit_q       <= '0;
      shreg_q     <= '0;
      bin_q       <= '0;
      sum_q       <= '0;
      idle_q      <= '0;
      word_data   <= '0;
      word_bin    <= '0;
      word_valid  <= 1'b0;
      frame_done  <= 1'b0;
      frame_sum   <= '0;
      framing_err <= 1'b0;
      frame_abort <= 1'b0;
    end else begin
      s1          <= serial_in;
      rx          <= s1;
      rx_d        <= rx;
      word_valid  <= 1'b0;
      frame_done  <= 1'b0;
      framing_err <= 1'b0;
      frame_abort <= 1'b0;

      if (state_d != state_q) tmr_q <= '0;
      else if (state_q != IDLE && state_q != WAIT_HIGH)
        tmr_q <= bit_end ? '0 : tmr_q + 1'b1;

      if (state_q == START) bit_q <= '0;
      if (data_smp) begin
        shreg_q <= {rx, shreg_q[DATA_WIDTH-1:1]};
        bit_q   <= bit_q + 1'b1;
      end

      // Good stop bit commits the word; a low stop bit discards it
      if (stop_smp) begin
        if (rx) begin
          word_valid <= 1'b1;
          word_data  <= shreg_q;
          word_bin   <= bin_q;
          if (last_bin) begin
            frame_done <= 1'b1;
            frame_sum  <= sum_nx;
            bin_q      <= '0;
            sum_q      <= '0;
          end else begin
            bin_q <= bin_q + 1'b1;
            sum_q <= sum_nx;
          end
        end else begin
          framing_err <= 1'b1;
        end
      end

      if (timeout) begin
        frame_abort <= 1'b1;
        bin_q       <= '0;
        sum_q       <= '0;
        idle_q      <= '0;
      end else if (idle_run) begin
        idle_q <= idle_q + 1'b1;
      end else begin
        idle_q <= '0;
      end
    end
  end

endmodule

// File: tb/tb_histo_uart_receiver.sv
// Directed bench for histo_uart_receiver: single word, full frame,
// framing error, glitch rejection, timeout abort, mid-word reset.
module tb_histo_uart_receiver;

  localparam int CPB = 10;
  localparam int NB  = 32;
  localparam int BW  = 5;
  localparam int SW  = 29;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          serial_in = 1'b1;
  logic [23:0]   word_data;
  logic [BW-1:0] word_bin;
  logic          word_valid;
  logic          frame_done;
  logic [SW-1:0] frame_sum;
  logic          framing_err;
  logic          frame_abort;
  logic          busy;

  int n_checks = 0;
  int n_fail   = 0;

  logic [23:0]   q_data[$];
  logic [BW-1:0] q_bin[$];
  logic          q_done[$];
  int ferr_cnt  = 0;
  int abort_cnt = 0;
  int done_cnt  = 0;
  int clash_cnt = 0;

  histo_uart_receiver #(
    .DATA_WIDTH  (24),
    .NUM_BINS    (NB),
    .BIN_WIDTH   (BW),
    .CLKS_PER_BIT(CPB),
    .TIMEOUT_CLKS(4096),
    .SUM_WIDTH   (SW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .serial_in  (serial_in),
    .word_data  (word_data),
    .word_bin   (word_bin),
    .word_valid (word_valid),
    .frame_done (frame_done),
    .frame_sum  (frame_sum),
    .framing_err(framing_err),
    .frame_abort(frame_abort),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n) begin
      if (word_valid) begin
        q_data.push_back(word_data);
        q_bin.push_back(word_bin);
        q_done.push_back(frame_done);
      end
      if (framing_err) ferr_cnt++;
      if (frame_abort) abort_cnt++;
      if (frame_done) done_cnt++;
      if ((framing_err || frame_abort) && word_valid) clash_cnt++;
    end
  end

  task automatic clear_mon();
    q_data.delete();
    q_bin.delete();
    q_done.delete();
    ferr_cnt  = 0;
    abort_cnt = 0;
    done_cnt  = 0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    serial_in = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    clear_mon();
  endtask

  task automatic drive_bit(input logic b);
    serial_in = b;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_word(input logic [23:0] d, input logic stop);
    drive_bit(1'b0);
    for (int i = 0; i < 24; i++) drive_bit(d[i]);
    drive_bit(stop);
    serial_in = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (word_valid !== 1'b0 || frame_done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_pulses valid=%b done=%b want 0",
               word_valid, frame_done);
    end
    n_checks++;
    if (framing_err !== 1'b0 || frame_abort !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_err ferr=%b abort=%b want 0",
               framing_err, frame_abort);
    end
    n_checks++;
    if (word_data !== 24'h0 || word_bin !== '0
        || frame_sum !== '0) begin
      n_fail++;
      $display("FAIL reset_data data=%h bin=%0d sum=%0d want 0",
               word_data, word_bin, frame_sum);
    end
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_busy got %b want 0", busy);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    clear_mon();
  endtask

  task automatic test_single();
    apply_reset();
    send_word(24'h00ABCD, 1'b1);
    repeat (5) @(negedge clk);
    n_checks++;
    if (q_data.size() != 1) begin
      n_fail++;
      $display("FAIL single_count got %0d want 1", q_data.size());
    end else begin
      n_checks++;
      if (q_data[0] !== 24'h00ABCD || q_bin[0] !== '0) begin
        n_fail++;
        $display("FAIL single_word data=%h bin=%0d want 00abcd/0",
                 q_data[0], q_bin[0]);
      end
    end
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL single_busy got %b want 0", busy);
    end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    for (int i = 0; i < NB; i++) send_word(24'(i + 1), 1'b1);
    repeat (5) @(negedge clk);
    n_checks++;
    if (q_data.size() != NB) begin
      n_fail++;
      $display("FAIL b2b_count got %0d want %0d", q_data.size(), NB);
    end else begin
      for (int i = 0; i < NB; i++) begin
        n_checks++;
        if (q_bin[i] !== BW'(i) || q_data[i] !== 24'(i + 1)
            || q_done[i] !== (i == NB - 1)) begin
          n_fail++;
          $display("FAIL b2b_word%0d bin=%0d data=%0d done=%b",
                   i, q_bin[i], q_data[i], q_done[i]);
        end
      end
    end
    n_checks++;
    if (done_cnt != 1) begin
      n_fail++;
      $display("FAIL b2b_done_cnt got %0d want 1", done_cnt);
    end
    n_checks++;
    if (frame_sum !== SW'(528)) begin
      n_fail++;
      $display("FAIL b2b_sum got %0d want 528", frame_sum);
    end
    clear_mon();
    send_word(24'h000777, 1'b1);
    repeat (3) @(negedge clk);
    n_checks++;
    if (q_bin.size() != 1 || word_bin !== '0
        || word_data !== 24'h000777) begin
      n_fail++;
      $display("FAIL b2b_wrap n=%0d bin=%0d data=%h want 1/0/000777",
               q_bin.size(), word_bin, word_data);
    end
    n_checks++;
    if (frame_sum !== SW'(528)) begin
      n_fail++;
      $display("FAIL b2b_sum_hold got %0d want 528", frame_sum);
    end
  endtask

  task automatic test_timeout();
    int w;
    for (int i = 0; i < 4; i++) send_word(24'h000100, 1'b1);
    clear_mon();
    w = 0;
    while (abort_cnt == 0 && w < 6000) begin
      @(negedge clk);
      w++;
    end
    n_checks++;
    if (abort_cnt != 1) begin
      n_fail++;
      $display("FAIL timeout_abort got %0d pulses want 1", abort_cnt);
    end
    n_checks++;
    if (w < 4090 || w > 4098) begin
      n_fail++;
      $display("FAIL timeout_delay got %0d cycles want ~4094", w);
    end
    n_checks++;
    if (frame_sum !== SW'(528) || done_cnt != 0) begin
      n_fail++;
      $display("FAIL timeout_sum sum=%0d done=%0d want 528/0",
               frame_sum, done_cnt);
    end
    send_word(24'h000042, 1'b1);
    repeat (3) @(negedge clk);
    n_checks++;
    if (q_bin.size() != 1 || word_bin !== '0) begin
      n_fail++;
      $display("FAIL timeout_next n=%0d bin=%0d want 1/0",
               q_bin.size(), word_bin);
    end
  endtask

  task automatic test_framing();
    apply_reset();
    send_word(24'hFFFFFF, 1'b0);
    repeat (20) @(negedge clk);
    n_checks++;
    if (ferr_cnt != 1 || q_data.size() != 0) begin
      n_fail++;
      $display("FAIL framing_err ferr=%0d words=%0d want 1/0",
               ferr_cnt, q_data.size());
    end
    send_word(24'h000001, 1'b1);
    repeat (3) @(negedge clk);
    n_checks++;
    if (q_data.size() != 1 || word_bin !== '0
        || word_data !== 24'h000001) begin
      n_fail++;
      $display("FAIL framing_next n=%0d bin=%0d data=%h want 1/0/1",
               q_data.size(), word_bin, word_data);
    end
  endtask

  task automatic test_glitch();
    apply_reset();
    serial_in = 1'b0;
    repeat (3) @(negedge clk);
    serial_in = 1'b1;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL glitch_busy_hi got %b want 1", busy);
    end
    repeat (4) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL glitch_busy_lo got %b want 0", busy);
    end
    repeat (20) @(negedge clk);
    n_checks++;
    if (q_data.size() != 0 || ferr_cnt != 0) begin
      n_fail++;
      $display("FAIL glitch_out words=%0d ferr=%0d want 0/0",
               q_data.size(), ferr_cnt);
    end
  endtask

  task automatic test_reset_mid();
    logic [23:0] d;
    apply_reset();
    send_word(24'h123456, 1'b1);
    repeat (3) @(negedge clk);
    clear_mon();
    d = 24'h5A5A5A;
    drive_bit(1'b0);
    for (int i = 0; i < 12; i++) drive_bit(d[i]);
    serial_in = d[12];
    repeat (CPB / 2) @(negedge clk);
    rst_n = 1'b0;
    serial_in = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (300) @(negedge clk);
    n_checks++;
    if (q_data.size() != 0 || ferr_cnt != 0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_quiet words=%0d ferr=%0d busy=%b",
               q_data.size(), ferr_cnt, busy);
    end
    n_checks++;
    if (word_data !== 24'h0) begin
      n_fail++;
      $display("FAIL rstmid_data got %h want 0", word_data);
    end
    send_word(24'h0000FE, 1'b1);
    repeat (3) @(negedge clk);
    n_checks++;
    if (q_data.size() != 1 || word_bin !== '0
        || word_data !== 24'h0000FE) begin
      n_fail++;
      $display("FAIL rstmid_next n=%0d bin=%0d data=%h want 1/0/fe",
               q_data.size(), word_bin, word_data);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_timeout();
    test_framing();
    test_glitch();
    test_reset_mid();
    n_checks++;
    if (clash_cnt != 0) begin
      n_fail++;
      $display("FAIL pulse_clash got %0d want 0", clash_cnt);
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
